convolver_window_controller: RTL and testbench

- Sequences the pixel stream into the convolver's shift-register line buffer.
- Accepts raster-order pixels through a valid/ready handshake and drives the buffer's shift enable.
- Tracks row and column position and flags the cycles in which the buffer's taps hold a complete, non-wrapping KERNEL_SIZE x KERNEL_SIZE window aligned to STRIDE.
- Sits between the input pixel source and the shift_register chain plus MAC array.

---
 rtl/convolver_window_controller_if.sv | 16 +
 rtl/convolver_window_controller.sv | 123 ++++++++++++
 tb/tb_convolver_window_controller.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/convolver_window_controller_if.sv
// Pixel handshake between the raster source and the window controller.
// The pixel data bus itself runs straight into the shift-register chain.
interface convolver_window_controller_if;
  logic pixel_valid;
  logic pixel_ready;

  modport master (
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/convolver_window_controller.sv
// Feeds the convolver line buffer one raster pixel per accept and
// flags cycles whose taps hold a complete, stride-aligned K x K window.
module convolver_window_controller #(
  parameter int KERNEL_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int STRIDE       = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  convolver_window_controller_if.slave    pix,
  output logic                            shift_enable,
  output logic                            window_valid,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] row_count,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  col_count,
  output logic [COUNT_WIDTH-1:0]          window_count,
  output logic                            busy,
  output logic                            done
);

  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [RW-1:0] ROW_K   = RW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_K   = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_END = CW'(IMAGE_WIDTH - 1);
  localparam logic [PW-1:0] PH_END  = PW'(STRIDE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          frame_end;
  logic          win;
  logic [PW-1:0] rph, cph;
  logic [PW-1:0] rph_cur, cph_cur;
  logic [PW-1:0] rph_nxt, cph_nxt;

  assign pix.pixel_ready = (state == S_STREAM);
  assign accept          = pix.pixel_valid & (state == S_STREAM);
  assign shift_enable    = accept;

  assign col_end   = (col_count == COL_END);
  assign row_end   = (row_count == ROW_END);
  assign frame_end = accept & col_end & row_end;

  // Phases restart at the first full-kernel row/column.
  assign cph_cur = (col_count == COL_K) ? '0 : cph;
  assign rph_cur = (row_count == ROW_K) ? '0 : rph;
  assign cph_nxt = (cph_cur == PH_END) ? '0 : cph_cur + PW'(1);
  assign rph_nxt = (rph_cur == PH_END) ? '0 : rph_cur + PW'(1);

  assign win = accept
             & (row_count >= ROW_K)
             & (col_count >= COL_K)
             & (rph_cur == '0)
             & (cph_cur == '0);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (frame_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      row_count    <= '0;
      col_count    <= '0;
      rph          <= '0;
      cph          <= '0;
      window_count <= '0;
      window_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      window_valid <= win;
      done         <= frame_end;
      if (state == S_IDLE && start) begin
        row_count    <= '0;
        col_count    <= '0;
        rph          <= '0;
        cph          <= '0;
        window_count <= '0;
      end else if (accept) begin
        if (win) window_count <= window_count + COUNT_WIDTH'(1);
        if (col_count >= COL_K) cph <= cph_nxt;
        if (col_end) begin
          col_count <= '0;
          row_count <= row_end ? '0 : row_count + RW'(1);
          if (row_count >= ROW_K) rph <= rph_nxt;
        end else begin
          col_count <= col_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_convolver_window_controller.sv
// Scoreboard bench: two controllers (5x5 stride 1, 7x7 stride 2)
// checked against an arithmetic window model per accepted pixel.
module tb_convolver_window_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        start_a, start_b;
  logic        shift_a, shift_b;
  logic        wv_a, wv_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic [2:0]  row_a, col_a, row_b, col_b;
  logic [15:0] wcnt_a, wcnt_b;

  convolver_window_controller_if if_a ();
  convolver_window_controller_if if_b ();

  convolver_window_controller #(
    .KERNEL_SIZE (3),
    .IMAGE_WIDTH (5),
    .IMAGE_HEIGHT(5),
    .STRIDE      (1),
    .COUNT_WIDTH (16)
  ) dut_a (
    .clock       (clock),
    .reset       (reset),
    .start       (start_a),
    .pix         (if_a.slave),
    .shift_enable(shift_a),
    .window_valid(wv_a),
    .row_count   (row_a),
    .col_count   (col_a),
    .window_count(wcnt_a),
    .busy        (busy_a),
    .done        (done_a)
  );

  convolver_window_controller #(
    .KERNEL_SIZE (3),
    .IMAGE_WIDTH (7),
    .IMAGE_HEIGHT(7),
    .STRIDE      (2),
    .COUNT_WIDTH (16)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .start       (start_b),
    .pix         (if_b.slave),
    .shift_enable(shift_b),
    .window_valid(wv_b),
    .row_count   (row_b),
    .col_count   (col_b),
    .window_count(wcnt_b),
    .busy        (busy_b),
    .done        (done_b)
  );

  logic        sel;
  logic        obs_ready, obs_shift, obs_wv, obs_busy, obs_done;
  logic [2:0]  obs_row, obs_col;
  logic [15:0] obs_wcnt;

  always_comb begin
    obs_ready = sel ? if_b.pixel_ready : if_a.pixel_ready;
    obs_shift = sel ? shift_b : shift_a;
    obs_wv    = sel ? wv_b : wv_a;
    obs_busy  = sel ? busy_b : busy_a;
    obs_done  = sel ? done_b : done_a;
    obs_row   = sel ? row_b : row_a;
    obs_col   = sel ? col_b : col_a;
    obs_wcnt  = sel ? wcnt_b : wcnt_a;
  end

  int checks   = 0;
  int failures = 0;

  task automatic drive(input bit v, input bit st);
    if (sel) begin
      if_b.pixel_valid = v;
      start_b          = st;
    end else begin
      if_a.pixel_valid = v;
      start_a          = st;
    end
  endtask

  // Streams pixels 0..lim-1 into the selected DUT; lim < w*h aborts early.
  task automatic run_frame(
    input bit s, input int w, input int h, input int k, input int st,
    input int gap_mod, input int lim, input bit chained,
    input bit spam, input bit start_next, input int exp_win
  );
    int q[$];
    int pix, cyc, prev, nwin, nshift, r, c, popped;
    bit v, exp_wv, finished;
    sel = s;
    if (!chained) begin
      @(posedge clock); #1 drive(1'b0, 1'b1);
    end
    @(posedge clock); #1 drive(1'b0, spam);
    @(negedge clock);
    checks++;
    if (obs_busy !== 1'b1 || obs_wcnt !== 16'd0 ||
        obs_row !== 3'd0 || obs_col !== 3'd0)
      begin
        failures++;
        $display("FAIL frame_start busy=%b wcnt=%0d row=%0d col=%0d want 1/0/0/0",
                 obs_busy, obs_wcnt, obs_row, obs_col);
      end
    pix = 0; cyc = 0; prev = -1; nwin = 0; nshift = 0; finished = 0;
    while (cyc < w * h * 3 + 20) begin
      v = (pix < lim) && !(gap_mod > 0 && (cyc % gap_mod) == gap_mod - 1);
      @(posedge clock); #1 drive(v, spam);
      @(negedge clock);
      exp_wv = (q.size() > 0) && (q[0] == prev);
      checks++;
      if (obs_wv !== exp_wv) begin
        failures++;
        $display("FAIL window_valid after_pix=%0d got=%b want=%b", prev, obs_wv, exp_wv);
      end
      if (exp_wv) popped = q.pop_front();
      if (obs_wv) nwin++;
      if (pix == lim) begin
        finished = 1;
        break;
      end
      checks++;
      if (obs_shift !== v || obs_ready !== 1'b1) begin
        failures++;
        $display("FAIL shift_enable cyc=%0d got=%b/%b want=%b/1", cyc, obs_shift, obs_ready, v);
      end
      if (obs_shift) nshift++;
      if (v) begin
        r = pix / w;
        c = pix % w;
        checks++;
        if (obs_row !== 3'(r) || obs_col !== 3'(c)) begin
          failures++;
          $display("FAIL position pix=%0d got=(%0d,%0d) want=(%0d,%0d)", pix, obs_row, obs_col, r, c);
        end
        if (r >= k - 1 && c >= k - 1 && (r - k + 1) % st == 0 && (c - k + 1) % st == 0)
          q.push_back(pix);
        prev = pix;
        pix++;
      end else begin
        prev = -1;
      end
      cyc++;
    end
    if (!finished) begin
      failures++;
      $display("FAIL timeout accepted=%0d want=%0d", pix, lim);
    end
    if (lim < w * h) return;
    checks++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b1 || obs_ready !== 1'b0 || obs_shift !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle done=%b busy=%b ready=%b shift=%b want 1/1/0/0",
               obs_done, obs_busy, obs_ready, obs_shift);
    end
    @(posedge clock); #1 drive(1'b0, start_next);
    @(negedge clock);
    checks++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done done=%b busy=%b want 0/0", obs_done, obs_busy);
    end
    checks++;
    if (obs_wcnt !== 16'(exp_win)) begin
      failures++;
      $display("FAIL window_count got=%0d want=%0d", obs_wcnt, exp_win);
    end
    checks++;
    if (nwin != exp_win || q.size() != 0) begin
      failures++;
      $display("FAIL window_total pulses=%0d want=%0d pending=%0d", nwin, exp_win, q.size());
    end
    checks++;
    if (nshift != w * h) begin
      failures++;
      $display("FAIL shift_total got=%0d want=%0d", nshift, w * h);
    end
    checks++;
    if (obs_row !== 3'd0 || obs_col !== 3'd0) begin
      failures++;
      $display("FAIL counters_end row=%0d col=%0d want 0/0", obs_row, obs_col);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    if_a.pixel_valid = 1'b0; if_b.pixel_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      checks++;
      if ({obs_ready, obs_shift, obs_wv, obs_busy, obs_done} !== 5'b0 ||
          obs_row !== 3'd0 || obs_col !== 3'd0 || obs_wcnt !== 16'd0) begin
        failures++;
        $display("FAIL reset dut=%0d flags=%b row=%0d col=%0d wcnt=%0d want all 0", d,
                 {obs_ready, obs_shift, obs_wv, obs_busy, obs_done}, obs_row, obs_col, obs_wcnt);
      end
    end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_idle_ignore();
    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1 drive(1'b1, 1'b0);
      @(negedge clock);
      checks++;
      if (obs_ready !== 1'b0 || obs_shift !== 1'b0 || obs_wv !== 1'b0 ||
          obs_busy !== 1'b0 || obs_row !== 3'd0 || obs_col !== 3'd0) begin
        failures++;
        $display("FAIL idle_ignore i=%0d ready=%b shift=%b wv=%b busy=%b row=%0d col=%0d want 0",
                 i, obs_ready, obs_shift, obs_wv, obs_busy, obs_row, obs_col);
      end
    end
    #1 drive(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 5, 5, 3, 1, 0, 25, 1'b0, 1'b0, 1'b0, 9);
  endtask

  task automatic test_gaps();
    run_frame(1'b0, 5, 5, 3, 1, 3, 25, 1'b0, 1'b0, 1'b0, 9);
  endtask

  task automatic test_stride();
    run_frame(1'b1, 7, 7, 3, 2, 0, 49, 1'b0, 1'b0, 1'b0, 9);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, 5, 5, 3, 1, 0, 10, 1'b0, 1'b0, 1'b0, 9);
    @(posedge clock); #1 reset = 1'b1; drive(1'b0, 1'b0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (obs_ready !== 1'b0 || obs_busy !== 1'b0 || obs_row !== 3'd0 ||
        obs_col !== 3'd0 || obs_wcnt !== 16'd0 || obs_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid ready=%b busy=%b row=%0d col=%0d wcnt=%0d done=%b want all 0",
               obs_ready, obs_busy, obs_row, obs_col, obs_wcnt, obs_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done i=%0d done=%b busy=%b want 0/0", i, obs_done, obs_busy);
      end
    end
    run_frame(1'b0, 5, 5, 3, 1, 0, 25, 1'b0, 1'b0, 1'b0, 9);
  endtask

  task automatic test_back_to_back_frames();
    run_frame(1'b0, 5, 5, 3, 1, 0, 25, 1'b0, 1'b1, 1'b1, 9);
    run_frame(1'b0, 5, 5, 3, 1, 0, 25, 1'b1, 1'b0, 1'b0, 9);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    test_reset();
    test_idle_ignore();
    test_back_to_back();
    test_gaps();
    test_stride();
    test_reset_mid_frame();
    test_back_to_back_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
